// File: rtl/uart_alu_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_alu_frame_ctrl
//
// Registered frame controller sitting between a UART RX/TX pair and a purely
// combinational ALU. It collects a three-byte command frame (A, B, Op) from
// RX and holds the operands on A/B/Op for the ALU. It then captures the ALU
// result and streams it to TX as RES_BYTES bytes, least significant byte
// first, pacing each byte on the TX done handshake.
//
// An inter-byte timeout drops a stalled partial frame. An overrun flag
// records bytes that arrive while a result is still being processed or sent.
//
// Ports
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   rx_done_tick  one-cycle pulse: rx_data_in holds a valid byte
//   rx_data_in    received byte
//   alu_result    ALU output, combinational from A/B/Op
//   tx_done_tick  one-cycle pulse: TX finished the current byte
//   tx_start      one-cycle pulse: start transmitting data_out
//   data_out      byte for TX, held stable from tx_start until tx_done_tick
//   A, B, Op      operand and opcode registers feeding the ALU
//   busy          high whenever the controller is not idle in WAIT_A
//   frame_error   one-cycle pulse when a partial frame is aborted by timeout
//   rx_overrun    sticky: a byte was dropped during CAPTURE/SEND/WAIT_TX;
//                 cleared by the next accepted A byte
// -----------------------------------------------------------------------------
module uart_alu_frame_ctrl #(
  parameter int NBIT_DATA_LEN  = 8,
  parameter int NBIT_OP_LEN    = 6,
  parameter int RES_BYTES      = 1,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               rx_done_tick,
  input  logic [NBIT_DATA_LEN-1:0]           rx_data_in,
  input  logic [NBIT_DATA_LEN*RES_BYTES-1:0] alu_result,
  input  logic                               tx_done_tick,
  output logic                               tx_start,
  output logic [NBIT_DATA_LEN-1:0]           data_out,
  output logic [NBIT_DATA_LEN-1:0]           A,
  output logic [NBIT_DATA_LEN-1:0]           B,
  output logic [NBIT_OP_LEN-1:0]             Op,
  output logic                               busy,
  output logic                               frame_error,
  output logic                               rx_overrun
);

  localparam int RES_W = NBIT_DATA_LEN * RES_BYTES;
  localparam int IDX_W = (RES_BYTES > 1) ? $clog2(RES_BYTES) : 1;
  // The counter only has to hold 0..TIMEOUT_CYCLES-1. The abort fires on the
  // cycle in which it would step to TIMEOUT_CYCLES.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RES_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_WAIT_A,
    S_WAIT_B,
    S_WAIT_OP,
    S_CAPTURE,
    S_SEND,
    S_WAIT_TX
  } state_t;

  state_t                   state_q, state_d;
  logic [NBIT_DATA_LEN-1:0] a_q, a_d;
  logic [NBIT_DATA_LEN-1:0] b_q, b_d;
  logic [NBIT_OP_LEN-1:0]   op_q, op_d;
  logic [NBIT_DATA_LEN-1:0] data_q, data_d;
  logic [RES_W-1:0]         res_q, res_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     tx_start_q, tx_start_d;
  logic                     frame_error_q, frame_error_d;
  logic                     overrun_q, overrun_d;
  logic                     busy_q, busy_d;

  logic                     timeout_hit;
  logic [RES_W-1:0]         res_shift;

  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST);
  assign res_shift   = res_q >> (NBIT_DATA_LEN * int'(idx_q));

  // NOTE: every variable gets a default before the case statement, so paths
  // that do not assign it hold state instead of inferring a latch.
  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    op_d          = op_q;
    data_d        = data_q;
    res_d         = res_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    tx_start_d    = 1'b0;
    frame_error_d = 1'b0;
    overrun_d     = overrun_q;

    unique case (state_q)
      S_WAIT_A: begin
        cnt_d = '0;
        if (rx_done_tick) begin
          a_d       = rx_data_in;
          overrun_d = 1'b0;
          state_d   = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        // An arriving byte takes priority over a timeout in the same cycle.
        if (rx_done_tick) begin
          b_d     = rx_data_in;
          cnt_d   = '0;
          state_d = S_WAIT_OP;
        end else if (timeout_hit) begin
          cnt_d         = '0;
          frame_error_d = 1'b1;
          state_d       = S_WAIT_A;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_OP: begin
        if (rx_done_tick) begin
          op_d    = rx_data_in[NBIT_OP_LEN-1:0];
          cnt_d   = '0;
          state_d = S_CAPTURE;
        end else if (timeout_hit) begin
          cnt_d         = '0;
          frame_error_d = 1'b1;
          state_d       = S_WAIT_A;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CAPTURE: begin
        // Op became visible to the ALU one cycle ago, so alu_result has settled.
        res_d   = alu_result;
        idx_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        data_d     = res_shift[NBIT_DATA_LEN-1:0];
        tx_start_d = 1'b1;
        state_d    = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (tx_done_tick) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_WAIT_A;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_SEND;
          end
        end
      end
      default: state_d = S_WAIT_A;
    endcase

    // Operands are frozen while a result is in flight; late bytes only flag.
    if (rx_done_tick &&
        (state_q == S_CAPTURE || state_q == S_SEND || state_q == S_WAIT_TX)) begin
      overrun_d = 1'b1;
    end

    busy_d = (state_d != S_WAIT_A);
  end

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_WAIT_A;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= '0;
      data_q        <= '0;
      res_q         <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      tx_start_q    <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      op_q          <= op_d;
      data_q        <= data_d;
      res_q         <= res_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      tx_start_q    <= tx_start_d;
      frame_error_q <= frame_error_d;
      overrun_q     <= overrun_d;
      busy_q        <= busy_d;
    end
  end

  assign tx_start    = tx_start_q;
  assign data_out    = data_q;
  assign A           = a_q;
  assign B           = b_q;
  assign Op          = op_q;
  assign busy        = busy_q;
  assign frame_error = frame_error_q;
  assign rx_overrun  = overrun_q;

endmodule

// File: tb/tb_uart_alu_frame_ctrl.sv
// -----------------------------------------------------------------------------
// Directed testbench for uart_alu_frame_ctrl.
// u_dut1: RES_BYTES=1, TIMEOUT_CYCLES=100, with an ALU model
//         (0x20 add, 0x22 subtract, else AND).
// u_dut2: RES_BYTES=2, TIMEOUT_CYCLES=0, with the ALU result modelled as {A,B}.
// Inputs are driven at falling edges and outputs are sampled at falling edges.
// -----------------------------------------------------------------------------
module tb_uart_alu_frame_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- instance 1 ----------------
  logic       rx1, tx_done1;
  logic [7:0] rxd1, alu1;
  logic       tx_start1, busy1, ferr1, ovr1;
  logic [7:0] data1, a1, b1;
  logic [5:0] op1;

  always_comb begin
    if (op1 == 6'h20)      alu1 = a1 + b1;
    else if (op1 == 6'h22) alu1 = a1 - b1;
    else                   alu1 = a1 & b1;
  end

  uart_alu_frame_ctrl #(
    .NBIT_DATA_LEN(8), .NBIT_OP_LEN(6), .RES_BYTES(1), .TIMEOUT_CYCLES(100)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rx_done_tick(rx1), .rx_data_in(rxd1),
    .alu_result(alu1), .tx_done_tick(tx_done1), .tx_start(tx_start1),
    .data_out(data1), .A(a1), .B(b1), .Op(op1), .busy(busy1),
    .frame_error(ferr1), .rx_overrun(ovr1)
  );

  // ---------------- instance 2 ----------------
  logic        rx2, tx_done2;
  logic [7:0]  rxd2;
  logic [15:0] alu2;
  logic        tx_start2, busy2, ferr2, ovr2;
  logic [7:0]  data2, a2, b2;
  logic [5:0]  op2;

  assign alu2 = {a2, b2};

  uart_alu_frame_ctrl #(
    .NBIT_DATA_LEN(8), .NBIT_OP_LEN(6), .RES_BYTES(2), .TIMEOUT_CYCLES(0)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .rx_done_tick(rx2), .rx_data_in(rxd2),
    .alu_result(alu2), .tx_done_tick(tx_done2), .tx_start(tx_start2),
    .data_out(data2), .A(a2), .B(b2), .Op(op2), .busy(busy2),
    .frame_error(ferr2), .rx_overrun(ovr2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Pulse counters, sampled 1 time unit after each rising edge.
  int starts1 = 0;
  int starts2 = 0;
  int ferrs1  = 0;
  int ferrs2  = 0;
  always @(posedge clk) begin
    #1;
    if (tx_start1) starts1++;
    if (tx_start2) starts2++;
    if (ferr1)     ferrs1++;
    if (ferr2)     ferrs2++;
  end

  // All driving tasks are entered at a falling edge and return at the next
  // falling edge, after the rising edge that sampled the stimulus.
  task automatic send1(input logic [7:0] d);
    rx1 = 1'b1; rxd1 = d;
    @(negedge clk);
    rx1 = 1'b0; rxd1 = 8'h00;
  endtask

  task automatic send2(input logic [7:0] d);
    rx2 = 1'b1; rxd2 = d;
    @(negedge clk);
    rx2 = 1'b0; rxd2 = 8'h00;
  endtask

  task automatic done1();
    tx_done1 = 1'b1;
    @(negedge clk);
    tx_done1 = 1'b0;
  endtask

  task automatic done2();
    tx_done2 = 1'b1;
    @(negedge clk);
    tx_done2 = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    n_cmp++; if ({tx_start1, data1, a1, b1, op1, busy1, ferr1, ovr1} !== '0) begin
      n_bad++; $display("FAIL reset_dut1: got %h want 0", {tx_start1, data1, a1, b1, op1, busy1, ferr1, ovr1}); end
    n_cmp++; if ({tx_start2, data2, a2, b2, op2, busy2, ferr2, ovr2} !== '0) begin
      n_bad++; $display("FAIL reset_dut2: got %h want 0", {tx_start2, data2, a2, b2, op2, busy2, ferr2, ovr2}); end
  endtask

  task automatic test_add();
    int s0;
    s0 = starts1;
    send1(8'h05); send1(8'h03); send1(8'h20);
    n_cmp++; if ({a1, b1, op1} !== {8'h05, 8'h03, 6'h20}) begin
      n_bad++; $display("FAIL add_operands: got %h %h %h want 05 03 20", a1, b1, op1); end
    n_cmp++; if (tx_start1 !== 1'b0 || busy1 !== 1'b1) begin
      n_bad++; $display("FAIL add_capture_cycle: tx_start=%b busy=%b want 0 1", tx_start1, busy1); end
    cycles(1);
    n_cmp++; if (tx_start1 !== 1'b0) begin
      n_bad++; $display("FAIL add_early_start: got %b want 0", tx_start1); end
    cycles(1);
    n_cmp++; if (tx_start1 !== 1'b1 || data1 !== 8'h08) begin
      n_bad++; $display("FAIL add_start: tx_start=%b data=%h want 1 08", tx_start1, data1); end
    cycles(1);
    n_cmp++; if (tx_start1 !== 1'b0 || data1 !== 8'h08 || busy1 !== 1'b1) begin
      n_bad++; $display("FAIL add_hold: tx_start=%b data=%h busy=%b want 0 08 1", tx_start1, data1, busy1); end
    cycles(2);
    done1();
    n_cmp++; if (busy1 !== 1'b0) begin
      n_bad++; $display("FAIL add_busy_drop: got %b want 0", busy1); end
    cycles(3);
    n_cmp++; if (starts1 - s0 !== 1) begin
      n_bad++; $display("FAIL add_start_count: got %0d want 1", starts1 - s0); end
  endtask

  task automatic test_op_mask();
    send1(8'h09); send1(8'h04); send1(8'hE2);
    n_cmp++; if (op1 !== 6'h22) begin
      n_bad++; $display("FAIL op_mask: got %h want 22", op1); end
    cycles(2);
    n_cmp++; if (tx_start1 !== 1'b1 || data1 !== 8'h05) begin
      n_bad++; $display("FAIL op_mask_result: tx_start=%b data=%h want 1 05", tx_start1, data1); end
    done1();
    // tx_done_tick while idle must be ignored.
    done1();
    cycles(1);
    n_cmp++; if (busy1 !== 1'b0 || tx_start1 !== 1'b0) begin
      n_bad++; $display("FAIL stray_done: busy=%b tx_start=%b want 0 0", busy1, tx_start1); end
  endtask

  task automatic test_timeout();
    int f0;
    int s0;
    f0 = ferrs1;
    send1(8'h11);
    cycles(99);
    n_cmp++; if (ferrs1 - f0 !== 0 || busy1 !== 1'b1) begin
      n_bad++; $display("FAIL timeout_early: frame_errors=%0d busy=%b want 0 1", ferrs1 - f0, busy1); end
    cycles(1);
    n_cmp++; if (ferr1 !== 1'b1 || busy1 !== 1'b0 || a1 !== 8'h11) begin
      n_bad++; $display("FAIL timeout_abort: frame_error=%b busy=%b A=%h want 1 0 11", ferr1, busy1, a1); end
    cycles(1);
    n_cmp++; if (ferr1 !== 1'b0) begin
      n_bad++; $display("FAIL timeout_pulse_width: got %b want 0", ferr1); end
    s0 = starts1;
    send1(8'h01); send1(8'h02); send1(8'h20);
    cycles(2);
    n_cmp++; if (a1 !== 8'h01 || tx_start1 !== 1'b1 || data1 !== 8'h03) begin
      n_bad++; $display("FAIL timeout_recover: A=%h tx_start=%b data=%h want 01 1 03", a1, tx_start1, data1); end
    done1();
    cycles(1);
    n_cmp++; if (starts1 - s0 !== 1 || ferrs1 - f0 !== 1) begin
      n_bad++; $display("FAIL timeout_counts: starts=%0d errors=%0d want 1 1", starts1 - s0, ferrs1 - f0); end
  endtask

  task automatic test_timeout_byte_wins();
    int f0;
    f0 = ferrs1;
    send1(8'h11);
    cycles(99);
    // This byte is sampled on the very edge at which the counter expires.
    send1(8'h22);
    n_cmp++; if (ferr1 !== 1'b0 || busy1 !== 1'b1 || b1 !== 8'h22) begin
      n_bad++; $display("FAIL byte_wins: frame_error=%b busy=%b B=%h want 0 1 22", ferr1, busy1, b1); end
    send1(8'h20);
    cycles(2);
    n_cmp++; if (tx_start1 !== 1'b1 || data1 !== 8'h33) begin
      n_bad++; $display("FAIL byte_wins_result: tx_start=%b data=%h want 1 33", tx_start1, data1); end
    done1();
    cycles(1);
    n_cmp++; if (ferrs1 - f0 !== 0) begin
      n_bad++; $display("FAIL byte_wins_no_error: got %0d want 0", ferrs1 - f0); end
  endtask

  task automatic test_overrun();
    send1(8'h10); send1(8'h20); send1(8'h20);
    cycles(2);
    n_cmp++; if (tx_start1 !== 1'b1 || data1 !== 8'h30 || ovr1 !== 1'b0) begin
      n_bad++; $display("FAIL ovr_start: tx_start=%b data=%h overrun=%b want 1 30 0", tx_start1, data1, ovr1); end
    send1(8'h77);
    n_cmp++; if ({a1, b1, op1} !== {8'h10, 8'h20, 6'h20} || ovr1 !== 1'b1 || data1 !== 8'h30) begin
      n_bad++; $display("FAIL ovr_hold: A=%h B=%h Op=%h overrun=%b data=%h want 10 20 20 1 30", a1, b1, op1, ovr1, data1); end
    done1();
    cycles(2);
    n_cmp++; if (ovr1 !== 1'b1 || busy1 !== 1'b0) begin
      n_bad++; $display("FAIL ovr_sticky: overrun=%b busy=%b want 1 0", ovr1, busy1); end
    send1(8'h01);
    n_cmp++; if (ovr1 !== 1'b0 || a1 !== 8'h01) begin
      n_bad++; $display("FAIL ovr_clear: overrun=%b A=%h want 0 01", ovr1, a1); end
    send1(8'h02); send1(8'h22);
    cycles(2);
    n_cmp++; if (tx_start1 !== 1'b1 || data1 !== 8'hFF) begin
      n_bad++; $display("FAIL ovr_next_frame: tx_start=%b data=%h want 1 ff", tx_start1, data1); end
    done1();
  endtask

  task automatic test_reset_mid_tx();
    int s0;
    send1(8'h40); send1(8'h02); send1(8'h22);
    cycles(2);
    send1(8'h55);
    n_cmp++; if (busy1 !== 1'b1 || ovr1 !== 1'b1 || data1 !== 8'h3E) begin
      n_bad++; $display("FAIL rst_setup: busy=%b overrun=%b data=%h want 1 1 3e", busy1, ovr1, data1); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({tx_start1, data1, a1, b1, op1, busy1, ferr1, ovr1} !== '0) begin
      n_bad++; $display("FAIL rst_async: got %h want 0", {tx_start1, data1, a1, b1, op1, busy1, ferr1, ovr1}); end
    @(negedge clk);
    rst_n = 1'b1;
    s0 = starts1;
    for (int i = 0; i < 4; i++) begin
      done1();
      cycles(1);
    end
    n_cmp++; if (starts1 - s0 !== 0 || busy1 !== 1'b0) begin
      n_bad++; $display("FAIL rst_no_start: starts=%0d busy=%b want 0 0", starts1 - s0, busy1); end
    send1(8'h07); send1(8'h01); send1(8'h20);
    cycles(2);
    n_cmp++; if (tx_start1 !== 1'b1 || data1 !== 8'h08) begin
      n_bad++; $display("FAIL rst_new_frame: tx_start=%b data=%h want 1 08", tx_start1, data1); end
    done1();
  endtask

  task automatic test_multi_byte();
    int s0;
    s0 = starts2;
    send2(8'hBE);
    // With the timeout disabled a stalled frame is never aborted.
    cycles(150);
    n_cmp++; if (busy2 !== 1'b1 || ferrs2 !== 0) begin
      n_bad++; $display("FAIL mb_no_timeout: busy=%b errors=%0d want 1 0", busy2, ferrs2); end
    send2(8'hEF); send2(8'h41);
    n_cmp++; if ({a2, b2, op2} !== {8'hBE, 8'hEF, 6'h01}) begin
      n_bad++; $display("FAIL mb_operands: A=%h B=%h Op=%h want be ef 01", a2, b2, op2); end
    cycles(2);
    n_cmp++; if (tx_start2 !== 1'b1 || data2 !== 8'hEF) begin
      n_bad++; $display("FAIL mb_byte0: tx_start=%b data=%h want 1 ef", tx_start2, data2); end
    cycles(3);
    done2();
    n_cmp++; if (tx_start2 !== 1'b0 || busy2 !== 1'b1) begin
      n_bad++; $display("FAIL mb_gap: tx_start=%b busy=%b want 0 1", tx_start2, busy2); end
    cycles(1);
    n_cmp++; if (tx_start2 !== 1'b1 || data2 !== 8'hBE) begin
      n_bad++; $display("FAIL mb_byte1: tx_start=%b data=%h want 1 be", tx_start2, data2); end
    cycles(2);
    done2();
    n_cmp++; if (busy2 !== 1'b0) begin
      n_bad++; $display("FAIL mb_busy_drop: got %b want 0", busy2); end
    cycles(3);
    n_cmp++; if (starts2 - s0 !== 2) begin
      n_bad++; $display("FAIL mb_start_count: got %0d want 2", starts2 - s0); end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    rx1 = 1'b0; rxd1 = 8'h00; tx_done1 = 1'b0;
    rx2 = 1'b0; rxd2 = 8'h00; tx_done2 = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_add();
    test_op_mask();
    test_timeout();
    test_timeout_byte_wins();
    test_overrun();
    test_reset_mid_tx();
    test_multi_byte();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule

// File: doc/uart_alu_frame_ctrl.md
Name: uart_alu_frame_ctrl

Overview:
- Registered frame controller between the UART RX/TX pair and the combinational ALU.
- Collects a 3-byte command frame (A, B, Op) from RX and presents the operands to the ALU.
- Captures the ALU result and streams it to TX as RES_BYTES bytes, LSB first, using the TX done handshake.
- Adds inter-byte timeout resync, an overrun flag, and a busy status.

Parameters:
- NBIT_DATA_LEN, 8, UART byte and ALU operand width.
- NBIT_OP_LEN, 6, opcode width; taken from the low bits of the Op byte (must be <= NBIT_DATA_LEN).
- RES_BYTES, 1, number of TX bytes per result; result width = NBIT_DATA_LEN*RES_BYTES.
- TIMEOUT_CYCLES, 50000, max clk cycles allowed between frame bytes; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_done_tick  in  1  one-cycle pulse, RX byte valid
- rx_data_in  in  NBIT_DATA_LEN  received byte
- alu_result  in  NBIT_DATA_LEN*RES_BYTES  ALU output, combinational from A/B/Op
- tx_done_tick  in  1  one-cycle pulse, TX finished current byte
- tx_start  out  1  one-cycle pulse, start TX of data_out
- data_out  out  NBIT_DATA_LEN  byte to TX, held stable from tx_start until tx_done_tick
- A  out  NBIT_DATA_LEN  operand A register
- B  out  NBIT_DATA_LEN  operand B register
- Op  out  NBIT_OP_LEN  opcode register
- busy  out  1  high in any state other than WAIT_A
- frame_error  out  1  one-cycle pulse on timeout abort
- rx_overrun  out  1  sticky; set when a byte arrives in CAPTURE/SEND/WAIT_TX; cleared on the next accepted A byte

Behaviour:
- Reset (async assert, sync release): state=WAIT_A; A, B, Op, data_out, result register, byte index and timeout counter = 0; tx_start, frame_error, rx_overrun = 0.
- All outputs are registered. There is no combinational path from any input to any output.
- States and transitions:
  - WAIT_A: on rx_done_tick, A<=rx_data_in; go to WAIT_B.
  - WAIT_B: on rx_done_tick, B<=rx_data_in; go to WAIT_OP.
  - WAIT_OP: on rx_done_tick, Op<=rx_data_in[NBIT_OP_LEN-1:0] (upper bits discarded); go to CAPTURE.
  - CAPTURE: one cycle so the ALU settles on the new Op; result register<=alu_result; byte index=0; go to SEND.
  - SEND: data_out<=result byte[idx]; tx_start=1 for exactly this one cycle; go to WAIT_TX.
  - WAIT_TX: on tx_done_tick, if idx==RES_BYTES-1 go to WAIT_A (busy drops next cycle); else idx+1 and go to SEND.
- Latency: Op byte rx_done_tick at cycle n gives Op valid at n+1, CAPTURE at n+1, tx_start at n+2.
- Timeout (TIMEOUT_CYCLES>0):
  - Counter resets on every rx_done_tick and runs only in WAIT_B and WAIT_OP.
  - When it reaches TIMEOUT_CYCLES: go to WAIT_A, pulse frame_error; A and B keep their values.
  - If rx_done_tick arrives in the same cycle the counter reaches TIMEOUT_CYCLES, the byte wins and is accepted.
- Bytes arriving in CAPTURE, SEND or WAIT_TX are dropped and set rx_overrun. A, B and Op stay unchanged, so the result is stable.
- tx_done_tick outside WAIT_TX is ignored.
- rst_n asserted mid-frame or mid-transmission aborts immediately. No further tx_start is issued. The partial frame is discarded.
- Byte order: byte[k] = result[(k+1)*NBIT_DATA_LEN-1 : k*NBIT_DATA_LEN], with k=0 sent first.

Test Plan:
- Reset, then bytes 0x05, 0x03, 0x20 (ADD) with alu_result=A+B modelled: A=0x05, B=0x03, Op=0x20; single tx_start pulse 2 cycles after the 3rd tick with data_out=0x08; busy returns to 0 one cycle after tx_done_tick.
- Op byte 0xE2 with NBIT_OP_LEN=6: Op=0x22; upper bits dropped.
- RES_BYTES=2, alu_result=0xBEEF: data_out=0xEF, then after tx_done_tick a second tx_start with data_out=0xBE; exactly 2 tx_start pulses.
- TIMEOUT_CYCLES=100: send 0x11, wait 100 cycles: frame_error pulses once, state=WAIT_A; then 0x01, 0x02, 0x20 yields a normal frame with A=0x01.
- Byte 0x77 injected while in WAIT_TX: A, B, Op unchanged, rx_overrun=1 until the next A byte is accepted; transmitted data matches the original result.
- rst_n pulled low in WAIT_TX: all outputs 0 asynchronously; no tx_start after release until a new 3-byte frame completes.
